// File: rtl/psum_buffer_ctrl.sv
// psum_buffer_ctrl: partial-sum scratchpad responder serving controller read and write/accumulate requests
module psum_buffer_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  global_rst,
   input  logic                  psum_buffer_ren,
   input  logic                  rst_psum_raddr,
   input  logic                  next_psum_raddr,
   input  logic                  next_psum_waddr,
   input  logic                  done,
   input  logic                  psum_mode,
   input  logic [DATA_WIDTH-1:0] psum_wdata,
   output logic                  can_read_psum,
   output logic                  psum_buffer_valid,
   output logic [DATA_WIDTH-1:0] psum_rdata,
   output logic [1:0]            stall,
   output logic                  psum_w_co
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DONE, WR_ACC, WR_ACK} state_t;
   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d, waddr_q, waddr_d, addr_q, addr_d;
   logic [DEPTH-1:0]        valid_q, valid_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d, sum_sat;
   logic                    mode_q, mode_d, sat_q, sat_d, ovf, mem_we;
   logic [DATA_WIDTH:0]     sum;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
   // one guard bit: overflow shows as a mismatch between the two top bits
   always_comb begin
      sum = ((mode_q && valid_q[addr_q]) ? {mem_q[addr_q][DATA_WIDTH-1], mem_q[addr_q]} : '0)
            + {wdata_q[DATA_WIDTH-1], wdata_q};
      ovf = sum[DATA_WIDTH] ^ sum[DATA_WIDTH-1];
      sum_sat = ovf ? (sum[DATA_WIDTH] ? SAT_MIN : SAT_MAX) : sum[DATA_WIDTH-1:0];
   end
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      mode_d  = mode_q;
      sat_d   = sat_q;
      rdata_d = rdata_q;
      valid_d = valid_q;
      mem_we  = 1'b0;
      raddr_d = (global_rst || rst_psum_raddr) ? '0 : next_psum_raddr ? raddr_q + 1'b1 : raddr_q;
      waddr_d = global_rst ? '0 : next_psum_waddr ? waddr_q + 1'b1 : waddr_q;
      case (state_q)
         IDLE: begin
            if (psum_buffer_ren && can_read_psum) begin
               state_d = RD_WAIT;
               addr_d  = raddr_q;
            end else if (done) begin
               state_d = WR_ACC;
               addr_d  = waddr_q;
               wdata_d = psum_wdata;
               mode_d  = psum_mode;
            end
         end
         RD_WAIT: begin
            state_d = RD_DONE;
            rdata_d = mem_q[addr_q];
         end
         RD_DONE: state_d = IDLE;
         WR_ACC: begin
            state_d         = WR_ACK;
            mem_we          = 1'b1;
            valid_d[addr_q] = 1'b1;
            sat_d           = ovf;
         end
         WR_ACK:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // a clear aborts whatever is in flight; storage itself is left untouched
      if (global_rst) begin
         state_d = IDLE;
         valid_d = '0;
         mem_we  = 1'b0;
         rdata_d = rdata_q;
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         raddr_q <= '0;
         waddr_q <= '0;
         addr_q  <= '0;
         valid_q <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         mode_q  <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         raddr_q <= raddr_d;
         waddr_q <= waddr_d;
         addr_q  <= addr_d;
         valid_q <= valid_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         mode_q  <= mode_d;
         sat_q   <= sat_d;
      end
   end
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[addr_q] <= sum_sat;
   end
   assign can_read_psum     = (state_q == IDLE) && valid_q[raddr_q];
   assign psum_buffer_valid = state_q == RD_DONE;
   assign psum_rdata        = rdata_q;
   assign stall             = (state_q == WR_ACK) ? {1'b1, sat_q} : 2'b00;
   assign psum_w_co         = &waddr_q;
endmodule

// File: tb/tb_psum_buffer_ctrl.sv
// tb_psum_buffer_ctrl: directed and random stimulus checked every cycle against a transaction-level model
module tb_psum_buffer_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        global_rst = 1'b0, psum_buffer_ren = 1'b0, rst_psum_raddr = 1'b0;
   logic        next_psum_raddr = 1'b0, next_psum_waddr = 1'b0, done = 1'b0, psum_mode = 1'b0;
   logic [15:0] psum_wdata = 16'd0;
   logic        can_read_psum, psum_buffer_valid, psum_w_co;
   logic [15:0] psum_rdata;
   logic [1:0]  stall;
   int          checks = 0, errors = 0;
   int          busy = 0, pend_a = 0, pend_val = 0, raddr_m = 0, waddr_m = 0;
   int          exp_rdata = 0, exp_stall = 0;
   bit          pend_rd = 0, pend_sat = 0, exp_pulse = 0;
   int          mem_m [8];
   bit          valid_m [8];

   psum_buffer_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
      .clk(clk), .reset(reset), .global_rst(global_rst), .psum_buffer_ren(psum_buffer_ren),
      .rst_psum_raddr(rst_psum_raddr), .next_psum_raddr(next_psum_raddr),
      .next_psum_waddr(next_psum_waddr), .done(done), .psum_mode(psum_mode),
      .psum_wdata(psum_wdata), .can_read_psum(can_read_psum),
      .psum_buffer_valid(psum_buffer_valid), .psum_rdata(psum_rdata), .stall(stall),
      .psum_w_co(psum_w_co)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      busy = 0; exp_pulse = 0; exp_rdata = 0; exp_stall = 0; raddr_m = 0; waddr_m = 0;
      for (int i = 0; i < 8; i++) valid_m[i] = 0;
   endtask

   // a request occupies the responder for the accepting edge plus two more; the
   // result becomes visible after the first of those
   task automatic model_step();
      int s;
      exp_pulse = 0;
      exp_stall = 0;
      if (global_rst) begin
         busy = 0; raddr_m = 0; waddr_m = 0;
         for (int i = 0; i < 8; i++) valid_m[i] = 0;
      end else begin
         if (busy == 2) begin
            if (pend_rd) begin
               exp_rdata = mem_m[pend_a];
               exp_pulse = 1;
            end else begin
               mem_m[pend_a] = pend_val;
               valid_m[pend_a] = 1;
               exp_stall = pend_sat ? 3 : 2;
            end
            busy = 1;
         end else if (busy == 1) begin
            busy = 0;
         end else if (psum_buffer_ren && valid_m[raddr_m]) begin
            busy = 2; pend_rd = 1; pend_a = raddr_m;
         end else if (done) begin
            s = (psum_mode && valid_m[waddr_m]) ? mem_m[waddr_m] + int'($signed(psum_wdata))
                                                : int'($signed(psum_wdata));
            pend_sat = (s > 32767) || (s < -32768);
            pend_val = (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
            busy = 2; pend_rd = 0; pend_a = waddr_m;
         end
         if (rst_psum_raddr) raddr_m = 0;
         else if (next_psum_raddr) raddr_m = (raddr_m + 1) % 8;
         if (next_psum_waddr) waddr_m = (waddr_m + 1) % 8;
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) model_reset();
      else model_step();
   end

   always @(negedge clk) begin
      chk("can_read", int'(can_read_psum), int'(busy == 0 && valid_m[raddr_m]));
      chk("valid", int'(psum_buffer_valid), int'(exp_pulse));
      chk("rdata", int'($signed(psum_rdata)), exp_rdata);
      chk("stall", int'(stall), exp_stall);
      chk("w_co", int'(psum_w_co), int'(waddr_m == 7));
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_waddr(input int a);
      for (int n = 0; n < 16 && waddr_m != a; n++) begin
         next_psum_waddr = 1'b1;
         tick();
         next_psum_waddr = 1'b0;
      end
   endtask

   task automatic set_raddr(input int a);
      rst_psum_raddr = 1'b1;
      tick();
      rst_psum_raddr = 1'b0;
      next_psum_raddr = 1'b1;
      repeat (a) tick();
      next_psum_raddr = 1'b0;
   endtask

   task automatic wr(input int a, input int d, input bit m, input int exp_st);
      set_waddr(a);
      done = 1'b1; psum_wdata = d[15:0]; psum_mode = m;
      tick();
      done = 1'b0;
      tick();
      chk("wr_stall", int'(stall), exp_st);
      tick();
   endtask

   task automatic rd(input int a, input int exp);
      if (a >= 0) set_raddr(a);
      psum_buffer_ren = 1'b1;
      tick();
      psum_buffer_ren = 1'b0;
      chk("rd_early", int'(psum_buffer_valid), 0);
      tick();
      chk("rd_pulse", int'(psum_buffer_valid), 1);
      chk("rd_data", int'($signed(psum_rdata)), exp);
      tick();
      chk("rd_once", int'(psum_buffer_valid), 0);
   endtask

   initial begin
      repeat (2) tick();
      chk("rst_can_read", int'(can_read_psum), 0);
      chk("rst_stall", int'(stall), 0);
      chk("rst_rdata", int'(psum_rdata), 0);
      reset = 1'b1;
      tick();
      wr(0, 5, 0, 2);
      rd(0, 5);
      wr(1, 100, 1, 2);
      wr(1, -30, 1, 2);
      rd(1, 70);
      wr(2, 7, 1, 2);
      rd(2, 7);
      wr(3, 32000, 0, 2);
      wr(3, 1000, 1, 3);
      rd(3, 32767);
      wr(4, -32000, 0, 2);
      wr(4, -1000, 1, 3);
      rd(4, -32768);
      set_waddr(6);
      chk("w_co_6", int'(psum_w_co), 0);
      set_waddr(7);
      chk("w_co_7", int'(psum_w_co), 1);
      set_waddr(0);
      chk("w_co_wrap", int'(psum_w_co), 0);
      set_raddr(1);
      rst_psum_raddr = 1'b1; next_psum_raddr = 1'b1;
      tick();
      rst_psum_raddr = 1'b0; next_psum_raddr = 1'b0;
      rd(-1, 5);
      set_waddr(5);
      psum_buffer_ren = 1'b1; done = 1'b1; psum_wdata = 16'd11; psum_mode = 1'b0;
      tick();
      psum_buffer_ren = 1'b0;
      tick();
      chk("both_pulse", int'(psum_buffer_valid), 1);
      chk("both_rdata", int'($signed(psum_rdata)), 5);
      chk("both_nostall", int'(stall), 0);
      repeat (2) tick();
      done = 1'b0;
      tick();
      chk("both_stall", int'(stall), 2);
      tick();
      rd(5, 11);
      global_rst = 1'b1;
      tick();
      global_rst = 1'b0;
      psum_buffer_ren = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("inv_novalid", int'(psum_buffer_valid), 0);
      end
      psum_buffer_ren = 1'b0;
      wr(0, 9, 0, 2);
      set_raddr(0);
      psum_buffer_ren = 1'b1;
      tick();
      psum_buffer_ren = 1'b0;
      #1 reset = 1'b0;
      #1;
      chk("ar_valid", int'(psum_buffer_valid), 0);
      chk("ar_rdata", int'(psum_rdata), 0);
      chk("ar_stall", int'(stall), 0);
      chk("ar_can_read", int'(can_read_psum), 0);
      chk("ar_w_co", int'(psum_w_co), 0);
      tick();
      reset = 1'b1;
      tick();
      done = 1'b1; psum_wdata = 16'd3;
      tick();
      done = 1'b0; global_rst = 1'b1;
      tick();
      global_rst = 1'b0;
      chk("gr_stall", int'(stall), 0);
      tick();
      chk("gr_stall2", int'(stall), 0);
      chk("gr_can_read", int'(can_read_psum), 0);
      repeat (3000) begin
         psum_buffer_ren = ($urandom_range(0, 9) < 3);
         done            = ($urandom_range(0, 9) < 3);
         psum_mode       = $urandom_range(0, 1) == 1;
         psum_wdata      = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 400)) - 16'd200;
         rst_psum_raddr  = ($urandom_range(0, 19) == 0);
         next_psum_raddr = ($urandom_range(0, 99) < 15);
         next_psum_waddr = ($urandom_range(0, 99) < 15);
         global_rst      = ($urandom_range(0, 49) == 0);
         tick();
      end
      {psum_buffer_ren, done, rst_psum_raddr, next_psum_raddr, next_psum_waddr, global_rst} = '0;
      repeat (4) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
